// File: rtl/instruction_encoder.sv
// Instruction encoder: accepts execute-state codes with operands over a valid/ready
// handshake, validates them and writes 16-bit program words to sequential memory addresses.
module instruction_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [7:0]        op_code,
  input  logic [11:0]       op_operand,
  input  logic              op_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  // Branch targets must fit the memory; shifting out the address bits leaves zero when ADDR_W = 12.
  function automatic logic op_legal(input logic [7:0] code, input logic [11:0] operand);
    logic in_range;
    logic is_branch;
    logic out_of_mem;
    in_range   = (code >= 8'h02) && (code <= 8'h0f);
    is_branch  = (code == 8'h05) || (code == 8'h08) || (code == 8'h0f);
    out_of_mem = (operand >> ADDR_W) != 12'd0;
    return in_range && !(is_branch && out_of_mem);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                mem_we_q, mem_we_d;
  logic                op_ready_q, op_ready_d;
  logic                busy_q, busy_d;

  // Next-state and next-output logic; strobes are derived from the next state so they are registered.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    word_count_d = word_count_q;
    mem_wdata_d  = mem_wdata_q;
    last_d       = last_q;
    done_d       = done_q;
    error_d      = error_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d      = S_LOAD;
          mem_addr_d   = {ADDR_W{1'b0}};
          word_count_d = {(ADDR_W+1){1'b0}};
          done_d       = 1'b0;
          error_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (op_valid) begin
          if (op_legal(op_code, op_operand)) begin
            mem_wdata_d = {op_code[3:0], op_operand};
            last_d      = op_last;
            state_d     = S_WRITE;
          end else begin
            error_d = 1'b1;
            state_d = S_ERR;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + {{ADDR_W{1'b0}}, 1'b1};
        if (mem_addr_q != ADDR_MAX) begin
          mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
          mem_addr_d = mem_addr_q;
        end
        // A last word on the final address is a clean finish, not an overflow.
        if (last_q) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (mem_addr_q == ADDR_MAX) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    mem_we_d   = (state_d == S_WRITE);
    op_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
  end

  // State and output registers; reset takes effect immediately and cancels any write in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      mem_addr_q   <= {ADDR_W{1'b0}};
      word_count_q <= {(ADDR_W+1){1'b0}};
      mem_wdata_q  <= 16'h0000;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      op_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      word_count_q <= word_count_d;
      mem_wdata_q  <= mem_wdata_d;
      last_q       <= last_d;
      done_q       <= done_d;
      error_q      <= error_d;
      mem_we_q     <= mem_we_d;
      op_ready_q   <= op_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign op_ready   = op_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, program-memory address width; legal range 4..12.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle pulse: begin a new program load at address 0.
REQ-005 op_valid  input  1  op_code/op_operand/op_last valid this cycle.
REQ-006 op_ready  output  1  encoder accepts an instruction this cycle.
REQ-007 op_code  input  8  execute-state code to encode (8'h02 and..8'h0f legal).
REQ-008 op_operand  input  12  address or immediate field.
REQ-009 op_last  input  1  this instruction is the final one of the program.
REQ-010 mem_we  output  1  program-memory write strobe.
REQ-011 mem_addr  output  ADDR_W  program-memory write address.
REQ-012 mem_wdata  output  16  encoded instruction word.
REQ-013 word_count  output  ADDR_W+1  instructions written since last start.
REQ-014 busy  output  1  high in LOAD or WRITE.
REQ-015 done  output  1  program loaded cleanly; held until next start.
REQ-016 error  output  1  load aborted; held until next start.

Function
REQ-017 FSM states: IDLE, LOAD, WRITE, DONE, ERR; op_ready = 1 only in LOAD.
REQ-018 IDLE/DONE/ERR: start -> LOAD; clears mem_addr, word_count, done, error.
REQ-019 start in LOAD or WRITE is ignored.
REQ-020 LOAD: handshake completes when op_valid and op_ready are both high; inputs sampled only then.
REQ-021 Encoding: mem_wdata = {op_code[3:0], op_operand[11:0]}; exact inverse of the decoder mapping of instruction bits [15:12] to execute states.
REQ-022 Legal op_code: 8'h02..8'h0f; 8'h00, 8'h01, 8'h10, 8'h11 and all others are illegal.
REQ-023 Branch check: for op_code 8'h05, 8'h08, 8'h0f, op_operand[11:ADDR_W] nonzero is illegal (target outside memory); no check when ADDR_W = 12.
REQ-024 Immediate/shift operands (8'h0b, 8'h0d, 8'h0e) pass unmodified, no range check.
REQ-025 Legal accepted instruction: mem_wdata registered, FSM -> WRITE next cycle.
REQ-026 Illegal accepted instruction: no write, error = 1, FSM -> ERR next cycle.
REQ-027 WRITE lasts exactly one cycle: mem_we = 1, mem_addr and mem_wdata stable throughout.
REQ-028 Leaving WRITE: word_count += 1; mem_addr += 1 unless at 2^ADDR_W-1 (held).
REQ-029 Leaving WRITE: captured op_last = 1 -> DONE; else mem_addr was 2^ADDR_W-1 -> ERR (overflow); else -> LOAD.
REQ-030 op_last on the final address word -> DONE, no error (exactly full is legal).
REQ-031 Throughput: one instruction per two cycles maximum; op_valid may idle indefinitely in LOAD.
REQ-032 mem_we = 0 in every state except WRITE; mem_wdata is don't-care when mem_we = 0.

Reset
REQ-033 resetn low forces immediately, regardless of clock: FSM = IDLE; mem_we, op_ready, busy, done, error = 0; mem_addr, word_count, mem_wdata = 0.
REQ-034 Reset asserted in WRITE suppresses the write in progress; no partial write after deassertion.
REQ-035 After resetn rises, outputs hold reset values until start.

Verification
REQ-036 start; send {8'h07,12'h010,0},{8'h03,12'h011,0},{8'h0a,12'h000,1} -> writes 16'h7010@0, 16'h3011@1, 16'ha000@2; done = 1, word_count = 3.
REQ-037 start; send {8'h11,12'h005,0} -> no mem_we, error = 1 next cycle, op_ready = 0; start again -> error = 0, mem_addr = 0.
REQ-038 ADDR_W = 8: send {8'h08,12'h100,1} -> error, no write; send {8'h0b,12'hfff,1} -> 16'hbfff written, done.
REQ-039 ADDR_W = 4: 16 instructions, op_last on 16th -> done, word_count = 16; repeat, op_last never set -> 16 writes then error, mem_addr held 4'hf.
REQ-040 resetn pulled low mid-WRITE, asynchronous to clock -> mem_we drops immediately, all outputs zero, FSM IDLE; op_valid ignored until start.
REQ-041 op_valid toggled randomly -> each instruction written exactly once, in order, mem_we one cycle each.
